// File: rtl/set_assoc_cache.sv
// Set-associative, write-back, write-allocate data cache with true-LRU replacement.
// Hits complete in one cycle; read misses and dirty evictions stall on a strobed RAM handshake.
module set_assoc_cache #(
    parameter int unsigned RAM_ADDRESS_BITS   = 32,
    parameter int unsigned CACHE_ADDRESS_BITS = 8,
    parameter int unsigned DATA_BITS          = 32,
    parameter int unsigned ASOC_BITS          = 2,
    parameter int unsigned BLOCK_BITS         = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [RAM_ADDRESS_BITS-1:0] address,
    input  logic                        read_en,
    input  logic [DATA_BITS-1:0]        write_data,
    input  logic                        write_en,
    input  logic                        ram_valid,
    input  logic [DATA_BITS-1:0]        ram_data [2**BLOCK_BITS],
    output logic [DATA_BITS-1:0]        read_data,
    output logic                        valid,
    output logic                        miss,
    output logic [RAM_ADDRESS_BITS-1:0] prop_address,
    output logic                        prop_read_en,
    output logic [DATA_BITS-1:0]        prop_write_data,
    output logic                        prop_write_en
);

    localparam int unsigned OFF   = BLOCK_BITS;
    localparam int unsigned IDX   = CACHE_ADDRESS_BITS - ASOC_BITS - BLOCK_BITS;
    localparam int unsigned TAGW  = RAM_ADDRESS_BITS - OFF - IDX;
    localparam int unsigned WAYS  = 2**ASOC_BITS;
    localparam int unsigned SETS  = 2**IDX;
    localparam int unsigned WORDS = 2**BLOCK_BITS;

    typedef enum logic [1:0] {StIdle, StWriteback, StFetch} state_e;

    state_e                      state_q;
    logic                        line_vld_q   [SETS][WAYS];
    logic                        line_dirty_q [SETS][WAYS];
    logic [ASOC_BITS-1:0]        line_lru_q   [SETS][WAYS];
    logic [TAGW-1:0]             line_tag_q   [SETS][WAYS];
    logic [DATA_BITS-1:0]        line_data_q  [SETS][WAYS][WORDS];

    logic [RAM_ADDRESS_BITS-1:0] req_addr_q;
    logic [DATA_BITS-1:0]        req_data_q;
    logic                        req_write_q;
    logic [ASOC_BITS-1:0]        vic_q;
    logic [BLOCK_BITS-1:0]       wb_cnt_q;

    logic [DATA_BITS-1:0]        rdata_q, pwdata_q;
    logic [RAM_ADDRESS_BITS-1:0] paddr_q;
    logic                        rvalid_q, miss_q, pread_q, pwrite_q;

    assign read_data       = rdata_q;
    assign valid           = rvalid_q;
    assign miss            = miss_q;
    assign prop_address    = paddr_q;
    assign prop_read_en    = pread_q;
    assign prop_write_data = pwdata_q;
    assign prop_write_en   = pwrite_q;

    // While stalled, the lookup works on the captured request rather than the live inputs.
    logic [RAM_ADDRESS_BITS-1:0] cur_addr;
    logic [DATA_BITS-1:0]        cur_wdata;
    logic [IDX-1:0]              cur_idx;
    logic [TAGW-1:0]             cur_tag;
    logic [OFF-1:0]              cur_off;
    logic                        hit, vic_found, vic_dirty, wb_last, wr_alloc, touch;
    logic [ASOC_BITS-1:0]        hit_way, victim, touch_way, touch_c;
    logic [ASOC_BITS-1:0]        lru_new [WAYS];
    logic [BLOCK_BITS-1:0]       wb_next;

    assign cur_addr  = (state_q == StIdle) ? address : req_addr_q;
    assign cur_wdata = (state_q == StIdle) ? write_data : req_data_q;
    assign cur_idx   = cur_addr[OFF+IDX-1:OFF];
    assign cur_tag   = cur_addr[RAM_ADDRESS_BITS-1:OFF+IDX];
    assign cur_off   = cur_addr[OFF-1:0];
    assign wb_next   = wb_cnt_q + 1'b1;
    assign wb_last   = (wb_cnt_q == BLOCK_BITS'(WORDS - 1));

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        vic_found = 1'b0;
        victim    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (line_vld_q[cur_idx][w] && line_tag_q[cur_idx][w] == cur_tag) begin
                hit     = 1'b1;
                hit_way = ASOC_BITS'(w);
            end
            if (!vic_found && !line_vld_q[cur_idx][w]) begin
                vic_found = 1'b1;
                victim    = ASOC_BITS'(w);
            end
        end
        if (!vic_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (line_lru_q[cur_idx][w] == '0) victim = ASOC_BITS'(w);
            end
        end
        vic_dirty = line_vld_q[cur_idx][victim] && line_dirty_q[cur_idx][victim];

        if (state_q != StIdle) begin
            touch_way = vic_q;
            touch_c   = '0;
        end else if (hit) begin
            touch_way = hit_way;
            touch_c   = line_lru_q[cur_idx][hit_way];
        end else begin
            touch_way = victim;
            touch_c   = '0;
        end
        for (int w = 0; w < WAYS; w++) begin
            lru_new[w] = (line_vld_q[cur_idx][w] && line_lru_q[cur_idx][w] > touch_c) ?
                         line_lru_q[cur_idx][w] - 1'b1 : line_lru_q[cur_idx][w];
        end
        lru_new[touch_way] = '1;

        wr_alloc = (state_q == StIdle && write_en && !hit && !vic_dirty) ||
                   (state_q == StWriteback && ram_valid && wb_last && req_write_q);
        touch    = (state_q == StIdle && (write_en || read_en) && hit) || wr_alloc ||
                   (state_q == StFetch && ram_valid);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    line_vld_q[s][w]   <= 1'b0;
                    line_dirty_q[s][w] <= 1'b0;
                    line_lru_q[s][w]   <= '0;
                    line_tag_q[s][w]   <= '0;
                    for (int k = 0; k < WORDS; k++) line_data_q[s][w][k] <= '0;
                end
            end
            state_q     <= StIdle;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_write_q <= 1'b0;
            vic_q       <= '0;
            wb_cnt_q    <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            miss_q      <= 1'b0;
            paddr_q     <= '0;
            pread_q     <= 1'b0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            if (touch) begin
                for (int w = 0; w < WAYS; w++) line_lru_q[cur_idx][w] <= lru_new[w];
            end
            if (wr_alloc) begin
                line_vld_q[cur_idx][touch_way]   <= 1'b1;
                line_dirty_q[cur_idx][touch_way] <= 1'b1;
                line_tag_q[cur_idx][touch_way]   <= cur_tag;
                for (int k = 0; k < WORDS; k++) begin
                    line_data_q[cur_idx][touch_way][k] <=
                        (BLOCK_BITS'(k) == cur_off) ? cur_wdata : '0;
                end
            end
            case (state_q)
                StIdle: begin
                    req_addr_q  <= address;
                    req_data_q  <= write_data;
                    req_write_q <= write_en;
                    vic_q       <= victim;
                    wb_cnt_q    <= '0;
                    if ((write_en || read_en) && !hit && vic_dirty) begin
                        state_q  <= StWriteback;
                        miss_q   <= 1'b1;
                        pwrite_q <= 1'b1;
                        paddr_q  <= {line_tag_q[cur_idx][victim], cur_idx, {OFF{1'b0}}};
                        pwdata_q <= line_data_q[cur_idx][victim][0];
                    end else if (write_en) begin
                        if (hit) begin
                            line_data_q[cur_idx][hit_way][cur_off] <= write_data;
                            line_dirty_q[cur_idx][hit_way]         <= 1'b1;
                        end
                    end else if (read_en) begin
                        if (hit) begin
                            rdata_q  <= line_data_q[cur_idx][hit_way][cur_off];
                            rvalid_q <= 1'b1;
                        end else begin
                            state_q <= StFetch;
                            miss_q  <= 1'b1;
                            pread_q <= 1'b1;
                            paddr_q <= {cur_tag, cur_idx, {OFF{1'b0}}};
                        end
                    end
                end
                StWriteback: begin
                    if (ram_valid) begin
                        if (wb_last) begin
                            pwrite_q <= 1'b0;
                            if (req_write_q) begin
                                state_q <= StIdle;
                                miss_q  <= 1'b0;
                            end else begin
                                state_q <= StFetch;
                                pread_q <= 1'b1;
                                paddr_q <= {cur_tag, cur_idx, {OFF{1'b0}}};
                            end
                        end else begin
                            wb_cnt_q <= wb_next;
                            pwdata_q <= line_data_q[cur_idx][vic_q][wb_next];
                        end
                    end
                end
                StFetch: begin
                    if (ram_valid) begin
                        for (int k = 0; k < WORDS; k++) line_data_q[cur_idx][vic_q][k] <= ram_data[k];
                        line_vld_q[cur_idx][vic_q]   <= 1'b1;
                        line_dirty_q[cur_idx][vic_q] <= 1'b0;
                        line_tag_q[cur_idx][vic_q]   <= cur_tag;
                        rdata_q  <= ram_data[cur_off];
                        rvalid_q <= 1'b1;
                        miss_q   <= 1'b0;
                        pread_q  <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Randomised scoreboard bench for set_assoc_cache against a recency-ordered cache model
// and a sparse backing-RAM model that also plays the RAM side of the handshake.
module tb_set_assoc_cache;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] address = '0;
    logic        read_en = 1'b0;
    logic [31:0] write_data = '0;
    logic        write_en = 1'b0;
    logic        ram_valid = 1'b0;
    logic [31:0] ram_data [4];
    logic [31:0] read_data;
    logic        valid, miss;
    logic [31:0] prop_address;
    logic        prop_read_en;
    logic [31:0] prop_write_data;
    logic        prop_write_en;

    set_assoc_cache dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .address        (address),
        .read_en        (read_en),
        .write_data     (write_data),
        .write_en       (write_en),
        .ram_valid      (ram_valid),
        .ram_data       (ram_data),
        .read_data      (read_data),
        .valid          (valid),
        .miss           (miss),
        .prop_address   (prop_address),
        .prop_read_en   (prop_read_en),
        .prop_write_data(prop_write_data),
        .prop_write_en  (prop_write_en)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit hold_ram = 1'b0;
    logic [31:0] last_rd = '0;

    // Model: each set holds up to four lines; the least recently stamped one is evicted.
    typedef struct {
        bit              v;
        bit              d;
        logic [25:0]     tag;
        logic [3:0][31:0] w;
        int unsigned     stamp;
    } mline_t;

    mline_t      ml [16][4];
    int unsigned now = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_q [$];
    logic [31:0] fill_q [$];
    logic [63:0] wb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            for (int i = 0; i < 4; i++) begin
                ml[s][i].v = 1'b0;
                ml[s][i].d = 1'b0;
                ml[s][i].stamp = 0;
            end
        end
    endtask

    task automatic model_access(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                                output bit em);
        int idx = int'(a[5:2]);
        int off = int'(a[1:0]);
        logic [25:0] tg = a[31:6];
        logic [31:0] la;
        int s = -1;
        now++;
        em = 1'b0;
        for (int i = 0; i < 4; i++) if (ml[idx][i].v && ml[idx][i].tag == tg) s = i;
        if (s >= 0) begin
            if (wr) begin
                ml[idx][s].w[off] = wd;
                ml[idx][s].d = 1'b1;
            end else begin
                rd_q.push_back(ml[idx][s].w[off]);
            end
        end else begin
            for (int i = 0; i < 4; i++) if (!ml[idx][i].v && s < 0) s = i;
            if (s < 0) begin
                s = 0;
                for (int i = 1; i < 4; i++) if (ml[idx][i].stamp < ml[idx][s].stamp) s = i;
            end
            if (ml[idx][s].v && ml[idx][s].d) begin
                em = 1'b1;
                la = {ml[idx][s].tag, a[5:2], 2'b00};
                for (int k = 0; k < 4; k++) begin
                    wb_q.push_back({la, ml[idx][s].w[k]});
                    mem[la + 32'(k)] = ml[idx][s].w[k];
                end
            end
            la = {tg, a[5:2], 2'b00};
            if (wr) begin
                ml[idx][s].w = '0;
                ml[idx][s].w[off] = wd;
                ml[idx][s].d = 1'b1;
            end else begin
                em = 1'b1;
                fill_q.push_back(la);
                for (int k = 0; k < 4; k++) ml[idx][s].w[k] = mem_rd(la + 32'(k));
                ml[idx][s].d = 1'b0;
                rd_q.push_back(ml[idx][s].w[off]);
            end
            ml[idx][s].v = 1'b1;
            ml[idx][s].tag = tg;
        end
        ml[idx][s].stamp = now;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (miss && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (miss) chk("stall_timeout", 32'(miss), 32'd0);
    endtask

    task automatic do_req(input logic [31:0] a, input bit wr, input bit rd, input logic [31:0] wd);
        bit em;
        @(negedge clk);
        address = a;
        write_en = wr;
        read_en = rd;
        write_data = wd;
        model_access(a, wr, wd, em);
        @(negedge clk);
        write_en = 1'b0;
        read_en = 1'b0;
        chk("miss_flag", 32'(miss), 32'(em));
        if (em && !hold_ram) wait_idle();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_read_data"}, read_data, 32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_miss"}, 32'(miss), 32'd0);
        chk({tag, "_prop_address"}, prop_address, 32'd0);
        chk({tag, "_prop_read_en"}, 32'(prop_read_en), 32'd0);
        chk({tag, "_prop_write_data"}, prop_write_data, 32'd0);
        chk({tag, "_prop_write_en"}, 32'(prop_write_en), 32'd0);
    endtask

    // Read-response monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (valid) begin
                if (rd_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got read_data %h with no read pending", read_data);
                end else begin
                    chk("read_data", read_data, rd_q.pop_front());
                end
                last_rd = read_data;
            end else if (reset_n) begin
                chk("read_hold", read_data, last_rd);
            end
        end
    end

    // RAM responder: random latency, checks every write-back word and fill address.
    initial begin
        logic [63:0] e;
        for (int k = 0; k < 4; k++) ram_data[k] = '0;
        forever begin
            @(negedge clk);
            ram_valid = 1'b0;
            if (!hold_ram && reset_n && (prop_write_en || prop_read_en)) begin
                if ($urandom_range(0, 2) != 0) begin
                    if (prop_write_en) begin
                        if (wb_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_writeback: got addr %h data %h",
                                     prop_address, prop_write_data);
                        end else begin
                            e = wb_q.pop_front();
                            chk("wb_addr", prop_address, e[63:32]);
                            chk("wb_data", prop_write_data, e[31:0]);
                        end
                    end else begin
                        if (fill_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_fill: got addr %h", prop_address);
                        end else begin
                            chk("fill_addr", prop_address, fill_q.pop_front());
                        end
                        for (int k = 0; k < 4; k++) ram_data[k] = mem_rd(prop_address + 32'(k));
                    end
                    ram_valid = 1'b1;
                end
            end else if (!hold_ram && reset_n && $urandom_range(0, 7) == 0) begin
                // Stray strobe while idle must be ignored.
                for (int k = 0; k < 4; k++) ram_data[k] = $urandom;
                ram_valid = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int r;
        model_reset();
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Cold read miss held for three cycles before the fill arrives.
        for (int k = 0; k < 4; k++) mem[32'(k)] = 32'd2;
        hold_ram = 1'b1;
        do_req(32'h0, 1'b0, 1'b1, 32'h0);
        repeat (3) @(negedge clk);
        chk("cold_prop_read_en", 32'(prop_read_en), 32'd1);
        chk("cold_prop_address", prop_address, 32'h0);
        chk("cold_miss_held", 32'(miss), 32'd1);
        hold_ram = 1'b0;
        wait_idle();
        do_req(32'h0, 1'b0, 1'b1, 32'h0);

        // Clean allocation and LRU ordering in set 0.
        do_req(32'h10000, 1'b1, 1'b0, 32'h10);
        do_req(32'h20000, 1'b1, 1'b0, 32'h10);
        do_req(32'h30000, 1'b1, 1'b0, 32'h30);
        do_req(32'h40000, 1'b1, 1'b0, 32'h40);
        do_req(32'h50000, 1'b0, 1'b1, 32'h0);
        do_req(32'h40000, 1'b0, 1'b1, 32'h0);

        // Overwrite and a run of consecutive words.
        do_req(32'h12345678, 1'b1, 1'b0, 32'hAC);
        do_req(32'h12345678, 1'b1, 1'b0, 32'hFFFFFFFF);
        for (int i = 1; i <= 24; i++) do_req(32'h12345678 + 32'(i), 1'b1, 1'b0, 32'h1000 + 32'(i));
        for (int i = 0; i <= 24; i++) do_req(32'h12345678 + 32'(i), 1'b0, 1'b1, 32'h0);

        // Random traffic confined to few sets and tags to force dirty evictions.
        for (int n = 0; n < 400; n++) begin
            a = (32'($urandom_range(0, 7)) << 6) | (32'($urandom_range(0, 3)) << 2) |
                32'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r < 4) do_req(a, 1'b1, 1'b0, $urandom);
            else if (r < 5) do_req(a, 1'b1, 1'b1, $urandom);
            else do_req(a, 1'b0, 1'b1, 32'h0);
        end

        // Reset asserted in the middle of a fill.
        @(negedge clk);
        #2 reset_n = 1'b0;
        last_rd = '0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        do_req(32'h100, 1'b1, 1'b0, 32'h5);
        hold_ram = 1'b1;
        do_req(32'h80, 1'b0, 1'b1, 32'h0);
        repeat (2) @(negedge clk);
        chk("fetch_prop_read_en", 32'(prop_read_en), 32'd1);
        chk("fetch_prop_address", prop_address, 32'h80);
        #2 reset_n = 1'b0;
        last_rd = '0;
        #1 check_outputs_zero("midreset");
        model_reset();
        rd_q.delete();
        fill_q.delete();
        wb_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        hold_ram = 1'b0;
        do_req(32'h100, 1'b0, 1'b1, 32'h0);
        do_req(32'h80, 1'b0, 1'b1, 32'h0);
        do_req(32'h100, 1'b0, 1'b1, 32'h0);

        repeat (4) @(negedge clk);
        chk("reads_outstanding", 32'(rd_q.size()), 32'd0);
        chk("fills_outstanding", 32'(fill_q.size()), 32'd0);
        chk("writebacks_outstanding", 32'(wb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
